// File: rtl/fpga_cfg_pkg.sv
// Fixed-point configuration shared by the LSM datapath blocks.
// Latency: n/a (constants only).
// Backpressure: n/a.
package fpga_cfg_pkg;
    localparam int FP_WIDTH = 32;  // signed two's complement word
    localparam int FP_QINT  = 15;  // integer bits (sign bit excluded)
    localparam int FP_QFRAC = 16;  // fraction bits
endpackage

// File: rtl/lsm_cashflow_store_if.sv
// Bundle between the decision stream / read-back clients and the cash-flow store.
// Latency: n/a (wires only).
// Backpressure: none; the stream is valid-only and reads are always accepted.
// master: drives step_start, valid_in, pv_in, rd_en, rd_idx; slave: drives the rest.
interface lsm_cashflow_store_if #(
    parameter int WIDTH      = 32,
    parameter int LOG2_NPATH = 10
);
    logic                                step_start;
    logic                                valid_in;
    logic signed [WIDTH-1:0]             pv_in;
    logic                                rd_en;
    logic [LOG2_NPATH-1:0]               rd_idx;
    logic                                rd_valid;
    logic signed [WIDTH-1:0]             rd_data;
    logic                                busy;
    logic                                step_done;
    logic signed [WIDTH+LOG2_NPATH-1:0]  sum_out;
    logic signed [WIDTH-1:0]             mean_out;
    logic [LOG2_NPATH:0]                 path_cnt;
    logic                                extra_err;

    modport master (
        output step_start, valid_in, pv_in, rd_en, rd_idx,
        input  rd_valid, rd_data, busy, step_done, sum_out, mean_out, path_cnt, extra_err
    );

    modport slave (
        input  step_start, valid_in, pv_in, rd_en, rd_idx,
        output rd_valid, rd_data, busy, step_done, sum_out, mean_out, path_cnt, extra_err
    );
endinterface

// File: rtl/lsm_cashflow_store.sv
// Per-step path cash-flow buffer with running sum and floor mean, plus registered read port.
// Latency: write visible to reads next cycle; read 1 cycle; step_done one edge after last write.
// Backpressure: none; accepts one pv per cycle, stray samples outside a step are dropped and flagged.
// Ports: clk, rst_n (async active-low); bus (slave) carries stream input, read port and status.
module lsm_cashflow_store
    import fpga_cfg_pkg::*;
#(
    parameter int WIDTH      = FP_WIDTH,
    parameter int QINT       = FP_QINT,
    parameter int QFRAC      = FP_QFRAC,
    parameter int LOG2_NPATH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lsm_cashflow_store_if.slave  bus
);
    localparam int NPATH = 1 << LOG2_NPATH;
    localparam int AW    = WIDTH + LOG2_NPATH;

    // Q-format is descriptive only; a mismatch leaves a marker scope in the hierarchy.
    if (QINT + QFRAC + 1 != WIDTH) begin : g_qfmt_mismatch
    end

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    state_t                  state;
    logic [LOG2_NPATH:0]     path_cnt;
    logic signed [AW-1:0]    acc;
    logic signed [AW-1:0]    sum_r;
    logic signed [WIDTH-1:0] mean_r;
    logic signed [WIDTH-1:0] rd_data_r;
    logic                    rd_valid_r;
    logic                    step_done_r;
    logic                    extra_err_r;

    logic signed [WIDTH-1:0] mem [NPATH];

    logic                    cnt_full;
    logic                    wr_en;
    logic signed [AW-1:0]    pv_ext;

    // path_cnt MSB set means all NPATH values of this step are in.
    assign cnt_full = path_cnt[LOG2_NPATH];
    assign wr_en    = (state == COLLECT) && bus.valid_in && !bus.step_start && !cnt_full;
    assign pv_ext   = {{LOG2_NPATH{bus.pv_in[WIDTH-1]}}, bus.pv_in};

    // Buffer holds no reset so it maps onto block RAM; old data wins on read/write collision.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[path_cnt[LOG2_NPATH-1:0]] <= bus.pv_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            path_cnt    <= '0;
            acc         <= '0;
            sum_r       <= '0;
            mean_r      <= '0;
            rd_data_r   <= '0;
            rd_valid_r  <= 1'b0;
            step_done_r <= 1'b0;
            extra_err_r <= 1'b0;
        end else begin
            rd_valid_r  <= bus.rd_en;
            if (bus.rd_en) begin
                rd_data_r <= mem[bus.rd_idx];
            end
            step_done_r <= 1'b0;

            if (bus.step_start) begin
                // A new step overrides everything, including a coincident sample.
                state       <= COLLECT;
                path_cnt    <= '0;
                acc         <= '0;
                extra_err_r <= 1'b0;
            end else begin
                case (state)
                    COLLECT: begin
                        if (cnt_full) begin
                            // Accumulator already holds the final total here.
                            state       <= DONE;
                            step_done_r <= 1'b1;
                            sum_r       <= acc;
                            mean_r      <= WIDTH'(acc >>> LOG2_NPATH);
                            if (bus.valid_in) begin
                                extra_err_r <= 1'b1;
                            end
                        end else if (bus.valid_in) begin
                            acc      <= acc + pv_ext;
                            path_cnt <= path_cnt + 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        if (bus.valid_in) begin
                            extra_err_r <= 1'b1;
                        end
                    end
                    IDLE: begin
                        if (bus.valid_in) begin
                            extra_err_r <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.busy      = (state == COLLECT);
    assign bus.path_cnt  = path_cnt;
    assign bus.sum_out   = sum_r;
    assign bus.mean_out  = mean_r;
    assign bus.step_done = step_done_r;
    assign bus.rd_valid  = rd_valid_r;
    assign bus.rd_data   = rd_data_r;
    assign bus.extra_err = extra_err_r;
endmodule

// File: tb/tb_lsm_cashflow_store.sv
module tb_lsm_cashflow_store;
    import fpga_cfg_pkg::*;

    localparam int W  = FP_WIDTH;
    localparam int L  = 2;
    localparam int NP = 1 << L;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    lsm_cashflow_store_if #(.WIDTH(W), .LOG2_NPATH(L)) bus();

    lsm_cashflow_store #(
        .WIDTH(W), .QINT(FP_QINT), .QFRAC(FP_QFRAC), .LOG2_NPATH(L)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference: what each path slot should hold, and the values of the next step.
    logic signed [W-1:0] model_mem [NP];
    logic signed [W-1:0] step_vals [NP];

    task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample mean rounded toward minus infinity.
    function automatic longint floor_mean(input longint s);
        longint q;
        q = s / NP;
        if ((s % NP) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    task automatic run_step(input bit gaps, input bit coincident);
        longint s;
        s = 0;
        bus.step_start = 1'b1;
        bus.valid_in   = coincident;
        bus.pv_in      = 32'h0000_7777;
        tick();
        bus.step_start = 1'b0;
        bus.valid_in   = 1'b0;
        chk("start_busy", bus.busy, 1);
        chk("start_cnt", bus.path_cnt, 0);
        chk("start_err", bus.extra_err, 0);
        for (int p = 0; p < NP; p++) begin
            if (gaps && $urandom_range(0, 1) == 1) begin
                bus.valid_in = 1'b0;
                tick();
            end
            bus.valid_in = 1'b1;
            bus.pv_in    = step_vals[p];
            tick();
            model_mem[p] = step_vals[p];
            s = s + longint'(step_vals[p]);
        end
        bus.valid_in = 1'b0;
        chk("full_cnt", bus.path_cnt, NP);
        chk("done_early", bus.step_done, 0);
        chk("busy_full", bus.busy, 1);
        tick();
        chk("done_pulse", bus.step_done, 1);
        chk("sum", bus.sum_out, s);
        chk("mean", bus.mean_out, floor_mean(s));
        chk("busy_done", bus.busy, 0);
        tick();
        chk("done_single", bus.step_done, 0);
    endtask

    task automatic read_one(input int idx);
        bus.rd_en  = 1'b1;
        bus.rd_idx = L'(idx);
        tick();
        chk("rd_valid", bus.rd_valid, 1);
        chk("rd_data", bus.rd_data, model_mem[idx]);
    endtask

    task automatic read_idle();
        bus.rd_en = 1'b0;
        tick();
        chk("rd_valid_off", bus.rd_valid, 0);
    endtask

    task automatic read_all_shuffled();
        int ord[NP];
        int j, t;
        for (int i = 0; i < NP; i++) ord[i] = i;
        for (int i = NP - 1; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = ord[i]; ord[i] = ord[j]; ord[j] = t;
        end
        for (int i = 0; i < NP; i++) read_one(ord[i]);
        read_idle();
    endtask

    task automatic random_vals();
        for (int p = 0; p < NP; p++) step_vals[p] = $signed($urandom);
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.step_start = 1'b0;
        bus.valid_in   = 1'b0;
        bus.pv_in      = '0;
        bus.rd_en      = 1'b0;
        bus.rd_idx     = '0;
        tick();
        tick();
        chk("rst_rd_valid", bus.rd_valid, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.step_done, 0);
        chk("rst_sum", bus.sum_out, 0);
        chk("rst_mean", bus.mean_out, 0);
        chk("rst_cnt", bus.path_cnt, 0);
        chk("rst_err", bus.extra_err, 0);
        rst_n = 1'b1;
        tick();

        // 1.0 .. 4.0 in Q16
        step_vals[0] = 32'h0001_0000; step_vals[1] = 32'h0002_0000;
        step_vals[2] = 32'h0003_0000; step_vals[3] = 32'h0004_0000;
        run_step(1'b0, 1'b0);
        chk("plan_sum", bus.sum_out, 64'h000A_0000);
        chk("plan_mean", bus.mean_out, 64'h0002_8000);
        read_one(3);
        read_one(0);
        read_one(2);
        read_idle();

        // negative values: floor of -5/4
        step_vals[0] = -1; step_vals[1] = -1; step_vals[2] = -1; step_vals[3] = -2;
        run_step(1'b0, 1'b0);
        chk("neg_sum", bus.sum_out, -5);
        chk("neg_mean", bus.mean_out, -2);

        // stray sample while idle
        bus.valid_in = 1'b1;
        bus.pv_in    = 32'h0012_3456;
        tick();
        bus.valid_in = 1'b0;
        chk("stray_err", bus.extra_err, 1);
        chk("stray_cnt", bus.path_cnt, NP);
        read_one(0);
        read_idle();

        // step_start coincident with valid_in clears the flag and drops the sample
        random_vals();
        run_step(1'b1, 1'b1);
        read_all_shuffled();

        // reset in the middle of a step
        random_vals();
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        for (int p = 0; p < 2; p++) begin
            bus.valid_in = 1'b1;
            bus.pv_in    = step_vals[p];
            tick();
            model_mem[p] = step_vals[p];
        end
        bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", bus.busy, 0);
        chk("abort_cnt", bus.path_cnt, 0);
        chk("abort_sum", bus.sum_out, 0);
        chk("abort_mean", bus.mean_out, 0);
        chk("abort_err", bus.extra_err, 0);
        tick();
        chk("abort_no_done", bus.step_done, 0);
        rst_n = 1'b1;
        tick();
        chk("abort_idle_done", bus.step_done, 0);
        random_vals();
        run_step(1'b0, 1'b0);
        read_all_shuffled();

        // read/write collision on path 1, then read-after-write on the next cycle
        random_vals();
        bus.step_start = 1'b1;
        tick();
        bus.step_start = 1'b0;
        bus.valid_in = 1'b1;
        bus.pv_in    = step_vals[0];
        tick();
        model_mem[0] = step_vals[0];
        bus.pv_in  = step_vals[1];
        bus.rd_en  = 1'b1;
        bus.rd_idx = L'(1);
        tick();
        chk("coll_valid", bus.rd_valid, 1);
        chk("coll_old", bus.rd_data, model_mem[1]);
        model_mem[1] = step_vals[1];
        bus.pv_in = step_vals[2];
        tick();
        chk("coll_new", bus.rd_data, model_mem[1]);
        model_mem[2] = step_vals[2];
        bus.rd_en = 1'b0;
        bus.pv_in = step_vals[3];
        tick();
        model_mem[3] = step_vals[3];
        bus.valid_in = 1'b0;
        tick();
        chk("coll_done", bus.step_done, 1);
        chk("coll_sum", bus.sum_out,
            longint'(step_vals[0]) + longint'(step_vals[1]) + longint'(step_vals[2]) + longint'(step_vals[3]));
        tick();
        read_all_shuffled();

        // randomized steps with gaps
        for (int k = 0; k < 4; k++) begin
            random_vals();
            run_step(1'b1, 1'b0);
            read_all_shuffled();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
